// File: rtl/basic_assert_stimulus_gen.sv
// Stimulus generator for an a-then-b assertion checker: drives trials, waits
// for a verdict (or times out), and tallies pass/fail/mismatch/timeout results.
module basic_assert_stimulus_gen #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_trials,
  input  logic [1:0]       mode,
  input  logic [7:0]       gap_cycles,
  input  logic [15:0]      seed,
  output logic             a,
  output logic             b,
  input  logic             chk_pass,
  input  logic             chk_fail,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE_A, S_DRIVE_B, S_WAIT_RESP, S_GAP, S_DONE
  } state_t;

  localparam logic [7:0]  TIMEOUT_W = 8'(TIMEOUT);
  localparam logic [15:0] SEED_DFLT = 16'hACE1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] ntr_q, ntr_d;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       gap_q, gap_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] trial_q, trial_d;
  logic [7:0]       wait_q, wait_d;
  logic [7:0]       gcnt_q, gcnt_d;
  logic             exp_b_q, exp_b_d;
  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d, mm_q, mm_d, to_q, to_d;
  logic             a_q, a_d, b_q, b_d, busy_q, busy_d, done_q, done_d;
  logic             trial_end, wait_exit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10).
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= '0;
      trial_q <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      mm_q    <= '0;
      to_q    <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      trial_q <= trial_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      mm_q    <= mm_d;
      to_q    <= to_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Run configuration and per-trial scratch need no reset: each is written
  // before the state that reads it.
  always_ff @(posedge clk) begin
    ntr_q   <= ntr_d;
    mode_q  <= mode_d;
    gap_q   <= gap_d;
    wait_q  <= wait_d;
    gcnt_q  <= gcnt_d;
    exp_b_q <= exp_b_d;
  end

  always_comb begin
    state_d   = state_q;
    ntr_d     = ntr_q;
    mode_d    = mode_q;
    gap_d     = gap_q;
    lfsr_d    = lfsr_q;
    trial_d   = trial_q;
    wait_d    = wait_q;
    gcnt_d    = gcnt_q;
    exp_b_d   = exp_b_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    mm_d      = mm_q;
    to_d      = to_q;
    trial_end = 1'b0;
    wait_exit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ntr_d   = num_trials;
          mode_d  = mode;
          gap_d   = gap_cycles;
          lfsr_d  = (seed == 16'h0) ? SEED_DFLT : seed;
          trial_d = '0;
          pass_d  = '0;
          fail_d  = '0;
          mm_d    = '0;
          to_d    = '0;
          state_d = (num_trials == '0) ? S_DONE : S_DRIVE_A;
        end
      end
      S_DRIVE_A: state_d = S_DRIVE_B;
      S_DRIVE_B: begin
        case (mode_q)
          2'b00:   exp_b_d = 1'b1;
          2'b01:   exp_b_d = 1'b0;
          2'b10:   exp_b_d = ~trial_q[0];
          default: exp_b_d = lfsr_q[0];
        endcase
        lfsr_d  = lfsr_step(lfsr_q);
        wait_d  = 8'd1;
        state_d = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        if (chk_pass && chk_fail) begin
          mm_d      = sat_inc(mm_q);
          wait_exit = 1'b1;
        end else if (chk_pass) begin
          if (exp_b_q) pass_d = sat_inc(pass_q);
          else         mm_d   = sat_inc(mm_q);
          wait_exit = 1'b1;
        end else if (chk_fail) begin
          if (!exp_b_q) fail_d = sat_inc(fail_q);
          else          mm_d   = sat_inc(mm_q);
          wait_exit = 1'b1;
        end else if (wait_q >= TIMEOUT_W) begin
          to_d      = sat_inc(to_q);
          wait_exit = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
        if (wait_exit) begin
          if (gap_q != 8'd0) begin
            gcnt_d  = gap_q;
            state_d = S_GAP;
          end else begin
            trial_end = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gcnt_q <= 8'd1) trial_end = 1'b1;
        else                gcnt_d    = gcnt_q - 8'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (trial_end) begin
      trial_d = trial_q + CNT_W'(1);
      state_d = (trial_d == ntr_q) ? S_DONE : S_DRIVE_A;
    end
  end

  // a/b lag the drive states by one cycle; busy/done track the state exactly.
  always_comb begin
    a_d    = (state_q == S_DRIVE_A);
    b_d    = (state_q == S_DRIVE_B) && exp_b_d;
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  assign a            = a_q;
  assign b            = b_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass_cnt     = pass_q;
  assign fail_cnt     = fail_q;
  assign mismatch_cnt = mm_q;
  assign timeout_cnt  = to_q;

endmodule

// File: tb/tb_basic_assert_stimulus_gen.sv
// Bench for basic_assert_stimulus_gen: a model checker answers each trial with a
// scripted verdict and latency; a trial-level reference model predicts the results.
module tb_basic_assert_stimulus_gen;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 8;
  localparam int MAXT    = 64;

  logic             clk = 1'b0;
  logic             rst, start;
  logic [CNT_W-1:0] num_trials;
  logic [1:0]       mode;
  logic [7:0]       gap_cycles;
  logic [15:0]      seed;
  logic             a, b, chk_pass, chk_fail, busy, done;
  logic [CNT_W-1:0] pass_cnt, fail_cnt, mismatch_cnt, timeout_cnt;

  always #5 clk = ~clk;

  basic_assert_stimulus_gen #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .num_trials(num_trials), .mode(mode),
    .gap_cycles(gap_cycles), .seed(seed), .a(a), .b(b),
    .chk_pass(chk_pass), .chk_fail(chk_fail), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .mismatch_cnt(mismatch_cnt),
    .timeout_cnt(timeout_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Checker script: 0 correct, 1 inverted, 2 both verdicts, 3 silent.
  int   resp_kind[MAXT];
  int   lat[MAXT];
  logic obs_b[MAXT];
  bit   noise = 1'b0;
  int   run_id = 0;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic int lfsr_next(input int s);
    int fb;
    fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
    return ((s << 1) | fb) & 32'hFFFF;
  endfunction

  // Model checker: sees a, samples b on the next cycle, answers lat cycles later.
  initial begin
    int ph, tr, last_id;
    ph = 99; tr = -1; last_id = 0;
    chk_pass = 1'b0; chk_fail = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (run_id != last_id) begin
        last_id = run_id; tr = -1; ph = 99;
      end
      chk_pass = 1'b0; chk_fail = 1'b0;
      if (a === 1'b1) begin
        tr++; ph = 0;
        if (noise) begin chk_pass = 1'b1; chk_fail = 1'b1; end
      end else if (ph < 99) begin
        ph++;
        if (tr >= 0 && tr < MAXT) begin
          if (ph == 1) obs_b[tr] = b;
          if (ph == 1 + lat[tr]) begin
            case (resp_kind[tr])
              0: begin chk_pass = obs_b[tr];  chk_fail = !obs_b[tr]; end
              1: begin chk_pass = !obs_b[tr]; chk_fail = obs_b[tr];  end
              2: begin chk_pass = 1'b1;       chk_fail = 1'b1;       end
              default: ;
            endcase
          end
        end
      end
    end
  end

  task automatic do_run(input string nm, input int ntr, input int md, input int gp,
                        input int sd, input int poke_at);
    int eb[MAXT];
    int e_pass, e_fail, e_mm, e_to, e_busy, s, wl, k;
    int busy_c, done_c, a_c, done_k;
    logic [31:0] sp, sf, sm, st;
    bit vp, vf;
    e_pass = 0; e_fail = 0; e_mm = 0; e_to = 0; e_busy = 0;
    busy_c = 0; done_c = 0; a_c = 0; done_k = 0;
    sp = '1; sf = '1; sm = '1; st = '1;
    s = (sd == 0) ? 32'hACE1 : sd;
    for (int i = 0; i < ntr; i++) begin
      case (md)
        0: eb[i] = 1;
        1: eb[i] = 0;
        2: eb[i] = (i % 2 == 0) ? 1 : 0;
        default: eb[i] = s & 1;
      endcase
      s = lfsr_next(s);
      if (resp_kind[i] == 3 || lat[i] >= TIMEOUT) begin
        e_to++;
        wl = TIMEOUT;
      end else begin
        wl = lat[i] + 1;
        vp = (resp_kind[i] == 2) || ((resp_kind[i] == 0) == (eb[i] == 1));
        vf = (resp_kind[i] == 2) || ((resp_kind[i] == 0) == (eb[i] == 0));
        if (vp && vf)      e_mm++;
        else if (vp)       begin if (eb[i] == 1) e_pass++; else e_mm++; end
        else               begin if (eb[i] == 0) e_fail++; else e_mm++; end
      end
      e_busy += 2 + wl + gp;
    end
    run_id++;
    @(negedge clk);
    num_trials = CNT_W'(ntr); mode = 2'(md); gap_cycles = 8'(gp); seed = 16'(sd);
    start = 1'b1;
    k = 0;
    while (k < e_busy + 40 && !(done_k != 0 && k >= done_k + 3)) begin
      @(negedge clk); k++;
      if (busy === 1'b1) busy_c++;
      if (a === 1'b1) a_c++;
      if (done === 1'b1) begin
        done_c++;
        if (done_k == 0) begin
          done_k = k;
          sp = pass_cnt; sf = fail_cnt; sm = mismatch_cnt; st = timeout_cnt;
        end
      end
      start = (k == poke_at);
      if (k == poke_at) num_trials = CNT_W'(ntr + 3);
    end
    expect_eq({nm, ".done_seen"}, (done_k != 0), 1);
    expect_eq({nm, ".done_latency"}, done_k, e_busy + 1);
    expect_eq({nm, ".done_pulses"}, done_c, 1);
    expect_eq({nm, ".busy_cycles"}, busy_c, e_busy);
    expect_eq({nm, ".a_pulses"}, a_c, ntr);
    expect_eq({nm, ".pass_at_done"}, sp, e_pass);
    expect_eq({nm, ".fail_at_done"}, sf, e_fail);
    expect_eq({nm, ".mism_at_done"}, sm, e_mm);
    expect_eq({nm, ".tmo_at_done"}, st, e_to);
    expect_eq({nm, ".pass_idle"}, pass_cnt, e_pass);
    expect_eq({nm, ".fail_idle"}, fail_cnt, e_fail);
    expect_eq({nm, ".mism_idle"}, mismatch_cnt, e_mm);
    expect_eq({nm, ".tmo_idle"}, timeout_cnt, e_to);
    for (int i = 0; i < ntr && i < MAXT; i++)
      expect_eq($sformatf("%s.b[%0d]", nm, i), obs_b[i], eb[i]);
  endtask

  task automatic set_script(input int kind, input int lt_lo, input int lt_hi);
    for (int i = 0; i < MAXT; i++) begin
      resp_kind[i] = (kind < 0) ? int'($urandom_range(0, 3)) : kind;
      lat[i] = int'($urandom_range(lt_lo, lt_hi));
    end
  endtask

  task automatic run_reset_mid();
    int a_c, wait_n, busy_c, done_c;
    a_c = 0; wait_n = -1; busy_c = 0; done_c = 0;
    set_script(3, 0, 0);
    noise = 1'b0;
    run_id++;
    @(negedge clk);
    num_trials = 5; mode = 2'b00; gap_cycles = 8'd1; seed = 16'h1234; start = 1'b1;
    for (int k = 0; k < 300 && wait_n != 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (a === 1'b1) begin
        a_c++;
        if (a_c == 3) wait_n = 2;
      end else if (wait_n > 0) begin
        wait_n--;
      end
    end
    expect_eq("rst.reached_trial3", wait_n, 0);
    expect_eq("rst.tmo_before", timeout_cnt, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_eq("rst.busy", busy, 0);
    expect_eq("rst.done", done, 0);
    expect_eq("rst.a", a, 0);
    expect_eq("rst.b", b, 0);
    expect_eq("rst.tmo", timeout_cnt, 0);
    expect_eq("rst.pass", pass_cnt, 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done === 1'b1) done_c++;
      if (busy === 1'b1) busy_c++;
    end
    expect_eq("rst.no_done", done_c, 0);
    expect_eq("rst.stays_idle", busy_c, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; num_trials = '0; mode = 2'b00; gap_cycles = 8'd0; seed = 16'd0;
    set_script(0, 1, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_eq("reset.a", a, 0);
    expect_eq("reset.b", b, 0);
    expect_eq("reset.busy", busy, 0);
    expect_eq("reset.done", done, 0);
    expect_eq("reset.pass", pass_cnt, 0);
    expect_eq("reset.fail", fail_cnt, 0);
    expect_eq("reset.mism", mismatch_cnt, 0);
    expect_eq("reset.tmo", timeout_cnt, 0);
    rst = 1'b0;

    set_script(0, 1, 1); noise = 1'b0;
    do_run("allpass", 4, 0, 2, 16'h0001, 4);

    set_script(0, 0, 3); noise = 1'b1;
    do_run("alternate", 6, 2, 0, 16'h0001, 0);

    set_script(3, 0, 0); noise = 1'b0;
    do_run("silent", 2, 1, 0, 16'h0001, 0);

    set_script(2, 0, 2); noise = 1'b0;
    do_run("faulty", 3, 0, 1, 16'h0001, 0);

    do_run("zero", 0, 0, 0, 16'h0001, 0);

    set_script(0, 1, 1); noise = 1'b0;
    do_run("lfsr_seed0", 8, 3, 0, 0, 0);

    for (int r = 0; r < 10; r++) begin
      set_script(-1, 0, TIMEOUT);
      noise = 1'($urandom_range(0, 1));
      do_run($sformatf("rand%0d", r), int'($urandom_range(1, 12)), r % 4,
             int'($urandom_range(0, 3)), (r == 3) ? 0 : int'($urandom_range(0, 65535)),
             (r == 5) ? 6 : 0);
    end

    run_reset_mid();

    set_script(1, 0, 1); noise = 1'b0;
    do_run("after_rst", 5, 3, 1, 16'hBEEF, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
